// File: rtl/seq_alu_core.sv
// seq_alu_core: 8-opcode sequential ALU with valid/ready handshakes, carry/zero flags and an iterative shift-add multiplier.
// Defining SEQ_ALU_ACC_EN adds an accumulator that captures every handed-off result and can replace operand A.
module seq_alu_core #(
  parameter int WIDTH  = 8,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_acc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_e;
  typedef enum logic [2:0] {
    OP_AND, OP_OR, OP_XOR, OP_ADD, OP_SUB, OP_SHL, OP_MUL, OP_PASS
  } op_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 carry_q, carry_d;
  logic                 zero_q, zero_d;
  logic [2*WIDTH-1:0]   mcand_q, mcand_d;
  logic [2*WIDTH-1:0]   prod_q, prod_d;
  logic [WIDTH-1:0]     mplier_q, mplier_d;
  logic [CW-1:0]        cnt_q, cnt_d;

  logic [WIDTH-1:0]     op_a;
  logic                 handoff;
  logic [WIDTH:0]       add_w, sub_w;
  logic [2*WIDTH-1:0]   shl_w, step_sum;
  logic [WIDTH-1:0]     alu_res;
  logic                 alu_carry;

  assign handoff = ena && (state_q == HOLD) && out_ready;

`ifdef SEQ_ALU_ACC_EN
  logic [WIDTH-1:0] acc_q;

  assign op_a = in_acc ? acc_q : in_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       acc_q <= '0;
    else if (handoff) acc_q <= result_q;
  end
`else
  logic unused_acc;

  assign unused_acc = in_acc;
  assign op_a       = in_a;
`endif

  // Single-cycle datapath; the shift keeps twice the width so shifted-out bits feed the carry.
  assign add_w    = {1'b0, op_a} + {1'b0, in_b};
  assign sub_w    = {1'b0, op_a} - {1'b0, in_b};
  assign shl_w    = {{WIDTH{1'b0}}, op_a} << in_b[CW-1:0];
  assign step_sum = prod_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    alu_res   = op_a;
    alu_carry = 1'b0;
    case (op_e'(in_op))
      OP_AND:  alu_res = op_a & in_b;
      OP_OR:   alu_res = op_a | in_b;
      OP_XOR:  alu_res = op_a ^ in_b;
      OP_ADD:  {alu_carry, alu_res} = add_w;
      OP_SUB:  {alu_carry, alu_res} = sub_w;
      OP_SHL:  begin
        alu_res   = shl_w[WIDTH-1:0];
        alu_carry = |shl_w[2*WIDTH-1:WIDTH];
      end
      default: alu_res = op_a;
    endcase
  end

  // NOTE: every next-state variable takes its hold value first, so no path through the block leaves one unassigned and infers a latch.
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    prod_d   = prod_q;
    cnt_d    = cnt_q;
    if (ena) begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            if (MUL_EN && (op_e'(in_op) == OP_MUL)) begin
              state_d  = MUL_BUSY;
              mcand_d  = {{WIDTH{1'b0}}, op_a};
              mplier_d = in_b;
              prod_d   = '0;
              cnt_d    = '0;
            end else begin
              state_d  = HOLD;
              result_d = alu_res;
              carry_d  = alu_carry;
              zero_d   = (alu_res == '0);
            end
          end
        end
        MUL_BUSY: begin
          prod_d   = step_sum;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) begin
            state_d  = HOLD;
            result_d = step_sum[WIDTH-1:0];
            carry_d  = |step_sum[2*WIDTH-1:WIDTH];
            zero_d   = (step_sum[WIDTH-1:0] == '0);
            cnt_d    = '0;
          end
        end
        HOLD: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples the pre-edge values together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      mcand_q  <= '0;
      mplier_q <= '0;
      prod_q   <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      prod_q   <= prod_d;
      cnt_q    <= cnt_d;
    end
  end

  assign in_ready   = ena && (state_q == IDLE);
  assign out_valid  = (state_q == HOLD);
  assign out_result = result_q;
  assign out_carry  = carry_q;
  assign out_zero   = zero_q;

endmodule

// File: tb/tb_seq_alu_core.sv
// Self-checking bench for seq_alu_core: directed vector table, handshake/freeze/reset sequences, and random ops against an arithmetic model.
module tb_seq_alu_core;
  localparam int     W    = 8;
  localparam longint MASK = (64'd1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst_n, ena, in_valid, in_ready, in_acc;
  logic         out_valid, out_ready, out_carry, out_zero;
  logic [W-1:0] in_a, in_b, out_result;
  logic [2:0]   in_op;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_alu_core #(.WIDTH(W), .MUL_EN(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_acc(in_acc),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_zero(out_zero)
  );

  typedef struct {
    int           op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] res;
    logic         cy;
    logic         z;
    int           lat;
    string        name;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic, then reduced modulo 2^W.
  function automatic void model(input int op, input longint a, input longint b,
                                output longint res, output longint cy);
    longint r;
    cy = 0;
    case (op)
      0: r = a & b;
      1: r = a | b;
      2: r = a ^ b;
      3: begin r = a + b;       cy = ((r >> W) != 0); end
      4: begin r = a - b;       cy = (a < b);         end
      5: begin r = a << (b % W); cy = ((r >> W) != 0); end
      6: begin r = a * b;       cy = ((r >> W) != 0); end
      default: r = a;
    endcase
    res = r & MASK;
  endfunction

  task automatic run_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic acc, input string name,
                        output logic [W-1:0] res, output logic cy, output logic z,
                        output int lat);
    int n = 0;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check({name, "_ready_timeout"}, 0, 1);
    in_valid = 1'b1;
    in_op    = op[2:0];
    in_a     = a;
    in_b     = b;
    in_acc   = acc;
    step();
    in_valid = 1'b0;
    in_acc   = 1'b0;
    lat      = 1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    res = out_result;
    cy  = out_carry;
    z   = out_zero;
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, out_valid, 0);
  endtask

  initial begin
    vec_t         vecs[13];
    logic [W-1:0] res;
    logic         cy, z;
    int           lat;
    longint       mres, mcy;

    vecs[0]  = '{3, 8'hF0, 8'h20, 8'h10, 1'b1, 1'b0, 1, "add_f0_20"};
    vecs[1]  = '{4, 8'h05, 8'h07, 8'hFE, 1'b1, 1'b0, 1, "sub_5_7"};
    vecs[2]  = '{4, 8'h07, 8'h07, 8'h00, 1'b0, 1'b1, 1, "sub_7_7"};
    vecs[3]  = '{6, 8'h0F, 8'h11, 8'hFF, 1'b0, 1'b0, W + 1, "mul_0f_11"};
    vecs[4]  = '{6, 8'h10, 8'h10, 8'h00, 1'b1, 1'b1, W + 1, "mul_10_10"};
    vecs[5]  = '{0, 8'hC3, 8'h5A, 8'h42, 1'b0, 1'b0, 1, "and"};
    vecs[6]  = '{1, 8'hC3, 8'h5A, 8'hDB, 1'b0, 1'b0, 1, "or"};
    vecs[7]  = '{2, 8'hC3, 8'h5A, 8'h99, 1'b0, 1'b0, 1, "xor"};
    vecs[8]  = '{5, 8'hC3, 8'h02, 8'h0C, 1'b1, 1'b0, 1, "shl_2"};
    vecs[9]  = '{5, 8'h81, 8'hF8, 8'h81, 1'b0, 1'b0, 1, "shl_0"};
    vecs[10] = '{7, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1, 1, "pass_0"};
    vecs[11] = '{6, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0, W + 1, "mul_ff_ff"};
    vecs[12] = '{3, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b1, 1, "add_wrap"};

    rst_n = 1'b0; ena = 1'b1; in_valid = 1'b0; in_acc = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0;

    // Reset state, before any clock edge.
    #3;
    check("rst_valid",  out_valid,  0);
    check("rst_result", out_result, 0);
    check("rst_carry",  out_carry,  0);
    check("rst_zero",   out_zero,   0);
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_in_ready", in_ready, 1);
    ena = 1'b0;
    #1;
    check("ena0_in_ready", in_ready, 0);
    ena = 1'b1;
    step();

    foreach (vecs[i]) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, 1'b0, vecs[i].name, res, cy, z, lat);
      check({vecs[i].name, "_res"},   res, vecs[i].res);
      check({vecs[i].name, "_carry"}, cy,  vecs[i].cy);
      check({vecs[i].name, "_zero"},  z,   vecs[i].z);
      check({vecs[i].name, "_lat"},   lat, vecs[i].lat);
      release_result(vecs[i].name);
    end

    // Backpressure: result stays put and a pending in_valid is never taken.
    run_op(3, 8'hFF, 8'h02, 1'b0, "bp", res, cy, z, lat);
    in_valid = 1'b1; in_op = 3'd0; in_a = 8'h00; in_b = 8'h00;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_valid",  out_valid,  1);
      check("bp_result", out_result, 8'h01);
      check("bp_carry",  out_carry,  1);
      check("bp_zero",   out_zero,   0);
      check("bp_ready",  in_ready,   0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    in_valid  = 1'b0;
    check("bp_handoff_drop", out_valid, 0);
    step();
    step();
    check("bp_no_second", out_valid, 0);

    // ena=0 for 3 cycles mid-MUL stretches latency by exactly 3.
    in_valid = 1'b1; in_op = 3'd6; in_a = 8'h0F; in_b = 8'h11;
    step();
    in_valid = 1'b0;
    lat = 1;
    step(); lat++;
    step(); lat++;
    ena = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(); lat++;
      check("frz_valid", out_valid, 0);
      check("frz_ready", in_ready,  0);
    end
    ena = 1'b1;
    while (!out_valid && lat < 100) begin
      step();
      lat++;
    end
    check("frz_lat",    lat,        W + 4);
    check("frz_result", out_result, 8'hFF);
    release_result("frz");

    // Reset abort mid-MUL clears outputs asynchronously.
    run_op(3, 8'hF0, 8'h20, 1'b0, "pre_abort", res, cy, z, lat);
    release_result("pre_abort");
    in_valid = 1'b1; in_op = 3'd6; in_a = 8'h0F; in_b = 8'h11;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("abort_valid",  out_valid,  0);
    check("abort_result", out_result, 0);
    check("abort_carry",  out_carry,  0);
    check("abort_zero",   out_zero,   0);
    step();
    rst_n = 1'b1;
    step();
    check("abort_in_ready", in_ready, 1);
    for (int i = 0; i < W + 2; i++) step();
    check("abort_no_result", out_valid, 0);

    // Random operations against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      int           op;
      logic [W-1:0] a, b;
      op = int'($urandom_range(0, 7));
      a  = W'($urandom);
      b  = W'($urandom);
      model(op, longint'(a), longint'(b), mres, mcy);
      run_op(op, a, b, 1'b0, "rnd", res, cy, z, lat);
      check("rnd_res",   res, mres);
      check("rnd_carry", cy,  mcy);
      check("rnd_zero",  z,   (mres == 0));
      check("rnd_lat",   lat, (op == 6) ? W + 1 : 1);
      release_result("rnd");
    end

    // Accumulator as operand A.
    run_op(3, 8'h03, 8'h04, 1'b0, "acc1", res, cy, z, lat);
    check("acc1_res", res, 8'h07);
    release_result("acc1");
    run_op(3, 8'h09, 8'h05, 1'b1, "acc2", res, cy, z, lat);
`ifdef SEQ_ALU_ACC_EN
    check("acc2_res", res, 8'h0C);
`else
    check("acc2_res", res, 8'h0E);
`endif
    release_result("acc2");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
